tthbif_cfg_bridge: RTL
======================

# tthbif_cfg_bridge

Parametrised UART-to-configuration bridge for the multi-lane tthbif link: decodes one- or two-byte commands from the UART receive stream and maintains an independent set of four tap-select fields per lane. It replaces the single shared tap-select set with per-lane and broadcast addressing, and returns an ACK, NAK or read-data byte for every command. It sits between the UART and the tthbif lane array inside the chip top.

## Interface
- NUM_LANES, 4, number of lanes (1..31)
- TAP_SEL_WIDTH, 2, width of each tap-select field (1..8)
- TIMEOUT_CYCLES, 65535, data-byte timeout in clk_i cycles (≥2); used only with the timeout feature
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  accept new command headers when high
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- rx_data_i  in  8  received UART byte
- tx_ready_i  in  1  UART transmitter can take a byte
- tx_valid_o  out  1  response byte valid
- tx_data_o  out  8  response byte
- rx_comb_tap_sel_o  out  NUM_LANES*TAP_SEL_WIDTH  per-lane fields; lane i at [i*W +: W], with W = TAP_SEL_WIDTH
- rx_flop_tap_sel_o  out  NUM_LANES*TAP_SEL_WIDTH  same layout
- tx_comb_tap_sel_o  out  NUM_LANES*TAP_SEL_WIDTH  same layout
- tx_flop_tap_sel_o  out  NUM_LANES*TAP_SEL_WIDTH  same layout
- cfg_update_o  out  1  one-cycle pulse when any field changes value

## Operation
- Header byte: [7] we; [6:5] field (0 rx_comb, 1 rx_flop, 2 tx_comb, 3 tx_flop); [4:0] lane. Lane 31 means broadcast.
- FSM states: IDLE, DATA, RESP.
- IDLE: rx_valid_i && en_i captures the header. A write goes to DATA. A read goes to RESP.
- DATA: the next rx_valid_i byte is the write data; its low W bits are used and the upper bits are ignored. Then go to RESP.
  - Lane < NUM_LANES: write that lane's field.
  - Lane 31: write the field in all lanes.
  - Lane in NUM_LANES..30: no write.
- RESP: hold tx_valid_o and tx_data_o stable until tx_ready_i is high, then go to IDLE.
- Response bytes:
  - Valid write: ACK 0xA5.
  - Read of a valid lane: field value, zero-extended.
  - Read of lane ≥ NUM_LANES, including broadcast: NAK 0xEE.
  - Write to an invalid lane: NAK 0xEE.
- rx_valid_i is ignored in RESP. It is also ignored in IDLE when en_i is low. There is no backpressure on rx; bytes ignored this way are lost.
- en_i gates only header capture. A command already in flight completes.
- cfg_update_o pulses only when a written value differs from the stored value in at least one lane.

## Timing
- Reset values: all tap-select outputs 0, tx_valid_o 0, tx_data_o 0x00, cfg_update_o 0, state IDLE.
- Read: header strobe at cycle N gives tx_valid_o high with data at N+1. Data reflects the field state at N+1, including any write completing at N.
- Write: data strobe at cycle M gives the field updated, cfg_update_o pulsed and tx_valid_o ACK, all at M+1.
- Handshake completes on a cycle where tx_valid_o && tx_ready_i. tx_valid_o falls at the next edge.
- Earliest next header acceptance is the cycle after the handshake.
- If tx_ready_i is already high at N+1, the response completes in one cycle.
- Reset asserted mid-command: FSM aborts immediately and all outputs return to reset values. No partial write.

## Configuration
- TTHBIF_CFG_TIMEOUT_EN defined:
  - A counter starts on entry to DATA.
  - If no data byte arrives within TIMEOUT_CYCLES cycles, go to IDLE, emit nothing and write nothing.
  - A data byte arriving on the expiry cycle is honoured.
- TTHBIF_CFG_TIMEOUT_EN undefined: no counter; DATA waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Package tthbif_cfg_pkg holds:
  - the state enum
  - the field enum
  - ACK (0xA5), NAK (0xEE) and BCAST_LANE (31) constants
  - the header bit-position constants
- Sub-module tthbif_cfg_regs is the per-lane register bank:
  - inputs: write enable, lane, broadcast, field, data
  - outputs: read mux, the four flattened buses and the change detect
- The FSM, response and timeout logic live in tthbif_cfg_bridge.

## Test plan
- Reset with NUM_LANES=4 → all buses 0, tx_valid_o 0; read header 0x02 (rx_comb lane 2) → tx_data_o 0x00.
- Write 0xA1, 0x03 (rx_flop lane 1 = 3) → rx_flop_tap_sel_o = 0x0C, cfg_update_o one pulse, ACK 0xA5; repeat the same write → ACK, no cfg_update_o pulse.
- Broadcast write 0xFF, 0x02 (tx_flop, lane 31) → tx_flop_tap_sel_o = 0xAA, ACK; then read 0x7F → NAK 0xEE.
- Write 0x86, 0x01 (lane 6 ≥ NUM_LANES) → NAK, no bus change; hold tx_ready_i low 10 cycles → tx_valid_o and tx_data_o stable; bytes sent meanwhile are ignored.
- With TTHBIF_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=16, send header 0xC0 with no data → return to IDLE after 16 cycles, no tx; next read 0x40 → 0x00.
- en_i low with a header byte → no response; en_i dropped between header and data byte → write completes with ACK.

Source files
------------

// File: rtl/tthbif_cfg_pkg.sv
// rtl/tthbif_cfg_pkg.sv - shared types and constants for the tthbif configuration bridge
package tthbif_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLD_RX_COMB = 2'd0,
        FLD_RX_FLOP = 2'd1,
        FLD_TX_COMB = 2'd2,
        FLD_TX_FLOP = 2'd3
    } field_t;

    localparam logic [7:0] ACK        = 8'hA5;
    localparam logic [7:0] NAK        = 8'hEE;
    localparam logic [4:0] BCAST_LANE = 5'd31;

    localparam int HDR_WE_BIT   = 7;
    localparam int HDR_FIELD_HI = 6;
    localparam int HDR_FIELD_LO = 5;
    localparam int HDR_LANE_HI  = 4;
    localparam int HDR_LANE_LO  = 0;

endpackage

// File: rtl/tthbif_cfg_regs.sv
// rtl/tthbif_cfg_regs.sv - per-lane tap-select register bank with read mux and change detect
module tthbif_cfg_regs
    import tthbif_cfg_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int TAP_SEL_WIDTH = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               wr_en,
    input  logic [4:0]                         lane,
    input  logic                               bcast,
    input  field_t                             field,
    input  logic [TAP_SEL_WIDTH-1:0]           wr_data,
    output logic [TAP_SEL_WIDTH-1:0]           rd_data,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] rx_comb_tap_sel,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] rx_flop_tap_sel,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] tx_comb_tap_sel,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] tx_flop_tap_sel,
    output logic                               changed
);

    localparam int W = TAP_SEL_WIDTH;

    logic [NUM_LANES*W-1:0] bank_q [4];
    logic [NUM_LANES-1:0]   lane_hit;

    always_comb begin
        lane_hit = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_hit[l] = bcast || (lane == 5'(l));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int f = 0; f < 4; f++) begin
                bank_q[f] <= '0;
            end
        end else if (wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_hit[l]) begin
                    bank_q[field][l*W +: W] <= wr_data;
                end
            end
        end
    end

    // Change detect looks at the pre-write contents of every targeted lane
    always_comb begin
        changed = 1'b0;
        rd_data = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_hit[l] && (bank_q[field][l*W +: W] != wr_data)) begin
                changed = 1'b1;
            end
            if (lane == 5'(l)) begin
                rd_data = bank_q[field][l*W +: W];
            end
        end
    end

    assign rx_comb_tap_sel = bank_q[FLD_RX_COMB];
    assign rx_flop_tap_sel = bank_q[FLD_RX_FLOP];
    assign tx_comb_tap_sel = bank_q[FLD_TX_COMB];
    assign tx_flop_tap_sel = bank_q[FLD_TX_FLOP];

endmodule

// File: rtl/tthbif_cfg_bridge.sv
// rtl/tthbif_cfg_bridge.sv - UART command decoder driving per-lane tap selects; optional TTHBIF_CFG_TIMEOUT_EN
module tthbif_cfg_bridge
    import tthbif_cfg_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int TAP_SEL_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic                               rx_valid_i,
    input  logic [7:0]                         rx_data_i,
    input  logic                               tx_ready_i,
    output logic                               tx_valid_o,
    output logic [7:0]                         tx_data_o,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] rx_comb_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] rx_flop_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] tx_comb_tap_sel_o,
    output logic [NUM_LANES*TAP_SEL_WIDTH-1:0] tx_flop_tap_sel_o,
    output logic                               cfg_update_o
);

    state_t                   state_q, next_state;
    logic [6:0]               hdr_q;
    logic [4:0]               cur_lane;
    field_t                   cur_field;
    logic                     lane_valid, is_bcast, wr_ok;
    logic                     hdr_load, wr_en, resp_load, timeout_hit;
    logic [7:0]               resp_data;
    logic [TAP_SEL_WIDTH-1:0] rd_data;
    logic                     changed;

    // In IDLE the header is decoded straight off the rx byte so a read can answer next cycle
    assign cur_lane   = (state_q == ST_IDLE) ? rx_data_i[HDR_LANE_HI:HDR_LANE_LO]
                                             : hdr_q[HDR_LANE_HI:HDR_LANE_LO];
    assign cur_field  = field_t'((state_q == ST_IDLE) ? rx_data_i[HDR_FIELD_HI:HDR_FIELD_LO]
                                                      : hdr_q[HDR_FIELD_HI:HDR_FIELD_LO]);
    assign lane_valid = (32'(cur_lane) < 32'(NUM_LANES));
    assign is_bcast   = (cur_lane == BCAST_LANE);
    assign wr_ok      = lane_valid || is_bcast;

    always_comb begin
        next_state = state_q;
        hdr_load   = 1'b0;
        wr_en      = 1'b0;
        resp_load  = 1'b0;
        resp_data  = NAK;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_i && en_i) begin
                    hdr_load = 1'b1;
                    if (rx_data_i[HDR_WE_BIT]) begin
                        next_state = ST_DATA;
                    end else begin
                        next_state = ST_RESP;
                        resp_load  = 1'b1;
                        resp_data  = lane_valid ? 8'(rd_data) : NAK;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    wr_en      = wr_ok;
                    resp_load  = 1'b1;
                    resp_data  = wr_ok ? ACK : NAK;
                    next_state = ST_RESP;
                end else if (timeout_hit) begin
                    next_state = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (tx_ready_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            tx_valid_o   <= 1'b0;
            tx_data_o    <= 8'h00;
            cfg_update_o <= 1'b0;
        end else begin
            state_q      <= next_state;
            tx_valid_o   <= (next_state == ST_RESP);
            cfg_update_o <= wr_en && changed;
            if (hdr_load) begin
                hdr_q <= rx_data_i[6:0];
            end
            if (resp_load) begin
                tx_data_o <= resp_data;
            end
        end
    end

`ifdef TTHBIF_CFG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;

    // The last DATA cycle (count TIMEOUT_CYCLES-1) still accepts a data byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != ST_DATA) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ST_DATA) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    tthbif_cfg_regs #(
        .NUM_LANES     (NUM_LANES),
        .TAP_SEL_WIDTH (TAP_SEL_WIDTH)
    ) u_regs (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .wr_en           (wr_en),
        .lane            (cur_lane),
        .bcast           (is_bcast),
        .field           (cur_field),
        .wr_data         (rx_data_i[TAP_SEL_WIDTH-1:0]),
        .rd_data         (rd_data),
        .rx_comb_tap_sel (rx_comb_tap_sel_o),
        .rx_flop_tap_sel (rx_flop_tap_sel_o),
        .tx_comb_tap_sel (tx_comb_tap_sel_o),
        .tx_flop_tap_sel (tx_flop_tap_sel_o),
        .changed         (changed)
    );

endmodule
